// File: rtl/mem_seq_pkg.sv
// ============================================================================
// mem_seq_pkg : shared types and helpers for the memory access sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_seq_pkg;

    localparam int WORD_W  = 20;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH1  = 2'd1,
        PH2  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_RD    = 2'd0,
        OP_WR    = 2'd1,
        OP_WR_RD = 2'd2,
        OP_RD_WR = 2'd3
    } op_t;

    // jmem dominates; stw only matters alongside memwrite; otherwise a read.
    function automatic op_t op_decode(input logic i_memwrite,
                                      input logic i_stw,
                                      input logic i_jmem);
        if (i_jmem)
            return OP_RD_WR;
        else if (i_memwrite && i_stw)
            return OP_WR_RD;
        else if (i_memwrite)
            return OP_WR;
        else
            return OP_RD;
    endfunction

    function automatic logic has_second(input op_t i_op);
        return (i_op == OP_WR_RD) || (i_op == OP_RD_WR);
    endfunction

    function automatic logic phase_is_write(input op_t i_op, input logic i_second);
        if (i_second)
            return (i_op == OP_RD_WR);
        else
            return (i_op == OP_WR) || (i_op == OP_WR_RD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_phase_timer.sv
// ============================================================================
// mem_phase_timer : per-phase wait counter, saturates and flags expiry
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_phase_timer
    import mem_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (r_cnt == CNT_W'(TIMEOUT));

endmodule

`default_nettype wire

// File: rtl/mem_access_sequencer.sv
// ============================================================================
// mem_access_sequencer : stalls the pipeline while running one or two
//                        single-port memory phases per load/store/jump op
// Revision             : 1.0
// ============================================================================
`default_nettype none

module mem_access_sequencer
    import mem_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              stw,
    input  logic              jmem,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [WORD_W-1:0] rdata,
    output logic              done,
    output logic              err
);

    state_t             r_state;
    state_t             w_next;
    op_t                r_op;
    logic [WORD_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_wdata;
    logic [WORD_W-1:0]  r_rdata;
    logic               r_err;

    logic w_req_in;
    logic w_in_phase;
    logic w_ack;
    logic w_expired;
    logic w_timeout;

    assign w_req_in   = memread || memwrite || jmem;
    assign w_in_phase = (r_state == PH1) || (r_state == PH2);
    assign w_ack      = w_in_phase && mem_ack;
    // An ack on the expiry cycle wins over the timeout.
    assign w_timeout  = w_in_phase && !mem_ack && w_expired;

    mem_phase_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_in_phase || mem_ack),
        .i_en      (w_in_phase && !mem_ack),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next  = r_state;
        stall   = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (r_state)
            IDLE: begin
                // rst gating keeps stall low while held in reset with a live request
                stall = w_req_in && !rst;
                if (w_req_in)
                    w_next = PH1;
            end
            PH1: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = phase_is_write(r_op, 1'b0);
                if (w_ack)
                    w_next = has_second(r_op) ? PH2 : DONE;
                else if (w_timeout)
                    w_next = DONE;
            end
            PH2: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = phase_is_write(r_op, 1'b1);
                if (w_ack || w_timeout)
                    w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                err    = r_err;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_RD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_err <= 1'b0;
                if (w_req_in) begin
                    r_op    <= op_decode(memwrite, stw, jmem);
                    r_addr  <= addr;
                    r_wdata <= wdata;
                end
            end
            if (w_timeout)
                r_err <= 1'b1;
            if (w_ack && !mem_we)
                r_rdata <= mem_rdata;
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;

endmodule

`default_nettype wire

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 memread  input  1  decoded control: instruction reads data memory.
REQ-004 memwrite  input  1  decoded control: instruction writes data memory.
REQ-005 stw  input  1  decoded control: with memwrite=1, selects store-then-readback.
REQ-006 jmem  input  1  decoded control: read-then-write memory jump; overrides stw/memread/memwrite.
REQ-007 addr  input  20  effective address from ALU.
REQ-008 wdata  input  20  store data (for jmem: link value).
REQ-009 stall  output  1  holds PC and instruction register while high.
REQ-010 mem_req  output  1  single-port memory request, held until mem_ack.
REQ-011 mem_we  output  1  1 = write phase, 0 = read phase; valid while mem_req=1.
REQ-012 mem_addr  output  20  memory address; valid while mem_req=1.
REQ-013 mem_wdata  output  20  memory write data; valid while mem_req=1 and mem_we=1.
REQ-014 mem_rdata  input  20  memory read data, valid in the cycle mem_ack=1 of a read phase.
REQ-015 mem_ack  input  1  memory completion; ignored when mem_req=0.
REQ-016 rdata  output  20  captured read word for writeback or jump target.
REQ-017 done  output  1  one-cycle pulse: access sequence complete.
REQ-018 err  output  1  one-cycle pulse coincident with done: a phase timed out.

Function
REQ-019 States SHALL be IDLE, PH1, PH2, DONE.
REQ-020 In IDLE, if memread|memwrite|jmem=1, stall SHALL be 1 combinationally, addr/wdata/op SHALL be latched, next state PH1.
REQ-021 Op decode precedence: jmem -> read then write; stw&memwrite -> write then read; memwrite -> write only; memread -> read only.
REQ-022 PH1/PH2: mem_req=1, mem_we per phase, mem_addr/mem_wdata from latched values, constant for the whole phase.
REQ-023 Phase ends on first cycle with mem_ack=1; next state PH2 if a second phase exists, else DONE.
REQ-024 On mem_ack in a read phase, rdata SHALL load mem_rdata; otherwise rdata holds its value.
REQ-025 stall SHALL be 1 in PH1 and PH2, 0 in DONE and in IDLE with no request.
REQ-026 DONE lasts exactly one cycle, asserts done, ignores all control inputs, then IDLE.
REQ-027 Minimum latency: single-phase with zero-wait ack = 2 stall cycles (IDLE accept, PH1), done on 3rd cycle; two-phase = 3 stall cycles.
REQ-028 A 4-bit phase counter SHALL clear on entering each phase and increment each cycle without ack; at count 15 with no ack, mem_req drops, err=1 in following DONE, remaining phase skipped.
REQ-029 mem_ack on the same cycle the counter reaches 15 SHALL count as success (no err).
REQ-030 Back-to-back requests: a new access is accepted only from IDLE, so minimum spacing is one idle cycle after DONE.

Reset
REQ-031 On rst=1, immediately: state IDLE, stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, done=0, err=0, counter=0.
REQ-032 rst asserted mid-phase SHALL abort the sequence with no done pulse; memory side sees mem_req fall asynchronously.

Structure
REQ-033 Shared package mem_seq_pkg SHALL hold WORD_W=20, TIMEOUT=15, state enum, op enum (OP_RD, OP_WR, OP_WR_RD, OP_RD_WR).
REQ-034 One sub-module, mem_phase_timer, SHALL implement the phase counter with clear/enable/expired.

Verification
REQ-035 lw: memread=1, addr=0x00010, ack next cycle with mem_rdata=0xABCDE -> one read phase, rdata=0xABCDE, stall 2 cycles, done pulse, err=0.
REQ-036 sw: memwrite=1, addr=0x00020, wdata=0x12345, ack after 3 wait cycles -> mem_we=1, addr/data stable 4 cycles, stall 5 cycles, done.
REQ-037 jmem: addr=0x00030, wdata=0x00100, mem_rdata=0x00400 -> read phase then write phase of 0x00100 to 0x00030, rdata=0x00400, stall 3 cycles.
REQ-038 stw: addr=0x00040, wdata=0x0F0F0 -> write then readback, rdata=0x0F0F0.
REQ-039 Timeout: memread=1, mem_ack never -> mem_req high 16 cycles, then done=1 and err=1 together, rdata unchanged; ack at 15th count -> no err.
REQ-040 Reset mid-PH2 of jmem -> all outputs zero same cycle, state IDLE, no done pulse.
